knight_cmd_link: RTL and testbench

Robot-side end of the remote command link. It deserialises two 8N1 UART bytes (high byte first) into one 16-bit command for the Knight command processor. It serialises a single 8-bit response byte (for example, the positive-ack 8'hA5) back to the remote. It sits between the RX/TX pins of the top level and the command FSM, and is the counterpart to the remote transmitter/receiver.

---
 rtl/knight_cmd_link_if.sv | 21 ++
 rtl/knight_cmd_link.sv | 209 ++++++++++++++++++++
 tb/tb_knight_cmd_link.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/knight_cmd_link_if.sv
// Command/response handshake between the UART link and the command processor.
// The link drives cmd/cmd_rdy/resp_sent/tx_busy; the consumer drives the rest.
interface knight_cmd_link_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        tx_busy;

  modport slave (
    output cmd, cmd_rdy, resp_sent, tx_busy,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport master (
    input  cmd, cmd_rdy, resp_sent, tx_busy,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/knight_cmd_link.sv
// Robot-side UART command link: two 8N1 bytes (high first) form a 16-bit command,
// and a single response byte is serialised back. RX and TX run independently.
module knight_cmd_link #(
  parameter int BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RX,
  output logic              TX,
  knight_cmd_link_if.slave  lnk
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic {ASM_HIGH, ASM_LOW} asm_state_t;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_t;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  // NOTE: sequential state is updated only with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
  logic [3:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_shreg_q, rx_shreg_d;
  logic            rx_expire, rx_byte_vld, rx_frm_err, rx_start_det;

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shreg_d   = rx_shreg_q;
    rx_byte_vld  = 1'b0;
    rx_frm_err   = 1'b0;
    rx_start_det = 1'b0;
    rx_expire    = (rx_cnt_q == CW'(1));
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_start_det = 1'b1;
          rx_cnt_d     = BAUD_HALF;
          rx_state_d   = RX_START;
        end
      end
      RX_START: begin
        rx_cnt_d = rx_cnt_q - CW'(1);
        if (rx_expire) begin
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = BAUD_FULL;
            rx_bit_d   = 4'd0;
          end
        end
      end
      RX_DATA: begin
        rx_cnt_d = rx_cnt_q - CW'(1);
        if (rx_expire) begin
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
          rx_cnt_d   = BAUD_FULL;
          rx_bit_d   = rx_bit_q + 4'd1;
          if (rx_bit_q == 4'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        rx_cnt_d = rx_cnt_q - CW'(1);
        if (rx_expire) begin
          rx_state_d  = RX_IDLE;
          rx_byte_vld = rx_sync_q;
          rx_frm_err  = !rx_sync_q;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  asm_state_t  asm_state_q, asm_state_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        cmd_set, cmd_clr;

  always_comb begin
    asm_state_d = asm_state_q;
    cmd_d       = cmd_q;
    cmd_set     = 1'b0;
    unique case (asm_state_q)
      ASM_HIGH: begin
        if (rx_byte_vld) begin
          cmd_d[15:8] = rx_shreg_q;
          asm_state_d = ASM_LOW;
        end
      end
      ASM_LOW: begin
        if (rx_byte_vld) begin
          cmd_d[7:0]  = rx_shreg_q;
          cmd_set     = 1'b1;
          asm_state_d = ASM_HIGH;
        end else if (rx_frm_err) begin
          asm_state_d = ASM_HIGH;
        end
      end
      default: asm_state_d = ASM_HIGH;
    endcase
    // A new high byte starting invalidates the previous command; a set wins over a clear.
    cmd_clr   = lnk.clr_cmd_rdy || (rx_start_det && asm_state_q == ASM_HIGH);
    cmd_rdy_d = cmd_set ? 1'b1 : (cmd_clr ? 1'b0 : cmd_rdy_q);
  end

  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_shreg_q, tx_shreg_d;
  logic          tx_q, tx_d;
  logic          resp_sent_q, resp_sent_d;
  logic          tx_expire;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_shreg_d  = tx_shreg_q;
    resp_sent_d = 1'b0;
    tx_expire   = (tx_cnt_q == CW'(1));
    unique case (tx_state_q)
      TX_IDLE: begin
        if (lnk.send_resp) begin
          tx_shreg_d = {1'b1, lnk.resp, 1'b0};
          tx_cnt_d   = BAUD_FULL;
          tx_bit_d   = 4'd0;
          tx_state_d = TX_XMIT;
        end
      end
      TX_XMIT: begin
        tx_cnt_d = tx_cnt_q - CW'(1);
        if (tx_expire) begin
          if (tx_bit_q == 4'd9) begin
            tx_state_d  = TX_IDLE;
            resp_sent_d = 1'b1;
          end else begin
            tx_shreg_d = {1'b1, tx_shreg_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
            tx_cnt_d   = BAUD_FULL;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Registering the next line value keeps TX glitch-free and puts the start edge 1 clk after send_resp.
    tx_d = (tx_state_d == TX_XMIT) ? tx_shreg_d[0] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shreg_q  <= '0;
      asm_state_q <= ASM_HIGH;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shreg_q  <= '1;
      tx_q        <= 1'b1;
      resp_sent_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shreg_q  <= rx_shreg_d;
      asm_state_q <= asm_state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shreg_q  <= tx_shreg_d;
      tx_q        <= tx_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  assign TX            = tx_q;
  assign lnk.cmd       = cmd_q;
  assign lnk.cmd_rdy   = cmd_rdy_q;
  assign lnk.resp_sent = resp_sent_q;
  assign lnk.tx_busy   = (tx_state_q == TX_XMIT);

endmodule

// File: tb/tb_knight_cmd_link.sv
// Bench for knight_cmd_link: drives 8N1 frames on RX, decodes TX at mid-bit and
// compares against a byte-level model of command assembly and response framing.
module tb_knight_cmd_link;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic RX;
  logic TX;

  knight_cmd_link_if lnk();

  knight_cmd_link #(.BAUD_DIV(BD)) dut (
    .clk (clk),
    .rst (rst),
    .RX  (RX),
    .TX  (TX),
    .lnk (lnk)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Byte-level reference: pending high byte, current command word, ready flag.
  logic [15:0] m_cmd;
  bit          m_rdy;
  bit          m_have_hi;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input bit stop_ok);
    logic [9:0] fr;
    fr = {stop_ok, b, 1'b0};
    // A start bit arriving while no high byte is pending begins a new command.
    if (!m_have_hi) m_rdy = 1'b0;
    for (int k = 0; k < 10 * BD; k++) begin
      RX = fr[k / BD];
      if (k == 12)         check("rdy_in_start_bit", lnk.cmd_rdy, m_rdy);
      if (k == 9 * BD + 4) check("rdy_before_stop_mid", lnk.cmd_rdy, m_rdy);
      tick(1);
    end
    RX = 1'b1;
    if (stop_ok) begin
      if (!m_have_hi) begin
        m_cmd[15:8] = b;
        m_have_hi   = 1'b1;
      end else begin
        m_cmd[7:0] = b;
        m_rdy      = 1'b1;
        m_have_hi  = 1'b0;
      end
    end else begin
      m_have_hi = 1'b0;
    end
    check("cmd_after_byte", lnk.cmd, m_cmd);
    check("rdy_after_byte", lnk.cmd_rdy, m_rdy);
    if (!stop_ok) tick(4);
  endtask

  task automatic rx_cmd(input logic [15:0] c);
    rx_byte(c[15:8], 1'b1);
    rx_byte(c[7:0], 1'b1);
  endtask

  task automatic clr_rdy();
    lnk.clr_cmd_rdy = 1'b1;
    tick(1);
    lnk.clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
    check("rdy_after_clr", lnk.cmd_rdy, m_rdy);
  endtask

  task automatic tx_frame(input logic [7:0] b, input bit retry40);
    logic [9:0] fr;
    int pulses;
    fr = {1'b1, b, 1'b0};
    pulses = 0;
    lnk.resp      = b;
    lnk.send_resp = 1'b1;
    tick(1);
    lnk.send_resp = 1'b0;
    check("tx_busy_start", lnk.tx_busy, 1);
    for (int c = 0; c < 10 * BD; c++) begin
      if (c % BD == BD / 2) check("tx_bit", TX, fr[c / BD]);
      if (lnk.resp_sent) pulses++;
      if (retry40 && c == 40) begin
        lnk.resp      = ~b;
        lnk.send_resp = 1'b1;
      end
      if (retry40 && c == 41) lnk.send_resp = 1'b0;
      tick(1);
    end
    check("resp_sent_early", pulses, 0);
    check("resp_sent_at_end", lnk.resp_sent, 1);
    check("tx_busy_end", lnk.tx_busy, 0);
    check("tx_idle_end", TX, 1);
    tick(1);
    check("resp_sent_one_clk", lnk.resp_sent, 0);
  endtask

  initial begin
    rst             = 1'b1;
    RX              = 1'b1;
    lnk.clr_cmd_rdy = 1'b0;
    lnk.send_resp   = 1'b0;
    lnk.resp        = 8'h00;
    m_cmd           = 16'h0000;
    m_rdy           = 1'b0;
    m_have_hi       = 1'b0;

    #23;
    check("rst_tx", TX, 1);
    check("rst_cmd", lnk.cmd, 16'h0000);
    check("rst_cmd_rdy", lnk.cmd_rdy, 0);
    check("rst_resp_sent", lnk.resp_sent, 0);
    check("rst_tx_busy", lnk.tx_busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    // Basic command, level-held ready, consumer clear.
    rx_cmd(16'h7000);
    tick(40);
    check("rdy_held", lnk.cmd_rdy, 1);
    check("cmd_held", lnk.cmd, 16'h7000);
    clr_rdy();

    // Unacknowledged command is dropped by the next high byte's start bit.
    rx_cmd(16'h1234);
    rx_cmd(16'h5678);
    check("cmd_5678", lnk.cmd, 16'h5678);
    clr_rdy();

    // Framing error on the low byte resynchronises the assembler.
    rx_byte(8'h11, 1'b1);
    rx_byte(8'h22, 1'b0);
    check("no_rdy_after_frm_err", lnk.cmd_rdy, 0);
    rx_cmd(16'hABCD);
    check("cmd_abcd", lnk.cmd, 16'hABCD);
    clr_rdy();

    // Short low glitch on the idle line must not produce a byte.
    RX = 1'b0;
    tick(3);
    RX = 1'b1;
    tick(30);
    check("glitch_rdy", lnk.cmd_rdy, 0);
    check("glitch_cmd", lnk.cmd, m_cmd);
    rx_cmd(16'h3C5A);
    clr_rdy();

    // Response frame with an ignored second strobe mid-frame.
    tx_frame(8'hA5, 1'b1);

    // Randomised full-duplex traffic.
    for (int i = 0; i < 6; i++) begin
      logic [15:0] c;
      logic [7:0]  r;
      c = 16'($urandom);
      r = 8'($urandom);
      fork
        rx_cmd(c);
        tx_frame(r, 1'b0);
      join
      if ($urandom_range(0, 1) == 1) clr_rdy();
    end

    // Reset in the middle of an RX high byte and a TX frame.
    lnk.resp      = 8'h3C;
    lnk.send_resp = 1'b1;
    tick(1);
    lnk.send_resp = 1'b0;
    RX = 1'b0;
    tick(60);
    #2 rst = 1'b1;
    #1;
    check("midrst_tx", TX, 1);
    check("midrst_tx_busy", lnk.tx_busy, 0);
    check("midrst_cmd_rdy", lnk.cmd_rdy, 0);
    check("midrst_cmd", lnk.cmd, 16'h0000);
    m_cmd     = 16'h0000;
    m_rdy     = 1'b0;
    m_have_hi = 1'b0;
    RX = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    check("post_rst_tx_busy", lnk.tx_busy, 0);
    rx_cmd(16'h2345);
    check("cmd_2345", lnk.cmd, 16'h2345);
    check("rdy_2345", lnk.cmd_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
